// File: rtl/xfabric_arb_pkg.sv
// Shared types and the round-robin search used by the fabric target arbiter.
// The search is generic up to RR_MAX_N initiators; callers pass their real count.
package xfabric_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    localparam int RR_MAX_N = 32;
    localparam int RR_IW    = 5;

    // First set bit of vld scanning last+1 .. last (with wrap) over n entries.
    function automatic logic [RR_IW-1:0] rr_next(
        input logic [RR_MAX_N-1:0] vld,
        input int                  n,
        input logic [RR_IW-1:0]    last
    );
        logic [RR_IW-1:0] pick;
        logic             found;
        int               c;
        pick  = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= RR_MAX_N; k++) begin
            if (k <= n && !found) begin
                c = int'(last) + k;
                if (c >= n) c = c - n;
                if (vld[c]) begin
                    pick  = RR_IW'(c);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/xfabric_rr_picker.sv
// Combinational round-robin pick: lowest-priority slot is the one granted last.
module xfabric_rr_picker
    import xfabric_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int OW = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vld,
    input  logic [OW-1:0] last,
    output logic          any,
    output logic [OW-1:0] idx
);

    always_comb begin
        any = |vld;
        idx = OW'(rr_next(RR_MAX_N'(vld), N, RR_IW'(last)));
    end

endmodule

// File: rtl/xfabric_tgt_arbiter.sv
// Shares one fabric target port between N_INIT initiators, one transaction in flight.
// Optional XFABRIC_ARB_LOCK_EN adds m_req_lock to keep ownership across back-to-back transfers.
module xfabric_tgt_arbiter
    import xfabric_arb_pkg::*;
#(
    parameter int N_INIT = 3,
    parameter int AW     = 21,
    parameter int DW     = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_INIT-1:0]      m_req_vld,
    input  logic [N_INIT-1:0]      m_req_wr,
    input  logic [N_INIT*AW-1:0]   m_req_adr,
    input  logic [N_INIT*DW/8-1:0] m_req_strb,
    input  logic [N_INIT*DW-1:0]   m_req_dat,
    output logic [N_INIT-1:0]      m_req_gnt,
    output logic [N_INIT-1:0]      m_rsp_vld,
    output logic [DW-1:0]          m_rsp_dat,
    input  logic [N_INIT-1:0]      m_rsp_gnt,
`ifdef XFABRIC_ARB_LOCK_EN
    input  logic [N_INIT-1:0]      m_req_lock,
`endif
    output logic                   s_req_vld,
    output logic                   s_req_wr,
    output logic [AW-1:0]          s_req_adr,
    output logic [DW/8-1:0]        s_req_strb,
    output logic [DW-1:0]          s_req_dat,
    input  logic                   s_req_gnt,
    input  logic                   s_rsp_vld,
    input  logic [DW-1:0]          s_rsp_dat,
    output logic                   s_rsp_gnt,
    output arb_state_t             dbg_state
);

    localparam int OW = (N_INIT > 2) ? $clog2(N_INIT) : 1;
    localparam int SW = DW / 8;

    // Handshake: a request or response transfers on the cycle where vld and gnt are both 1;
    // the sender holds vld and payload stable until then.
    arb_state_t    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic          pick_any;
    logic [OW-1:0] pick_idx;

    xfabric_rr_picker #(.N(N_INIT), .OW(OW)) u_picker (
        .vld  (m_req_vld),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= OW'(N_INIT - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        m_req_gnt  = '0;
        m_rsp_vld  = '0;
        m_rsp_dat  = s_rsp_dat;
        s_req_vld  = 1'b0;
        s_req_wr   = 1'b0;
        s_req_adr  = '0;
        s_req_strb = '0;
        s_req_dat  = '0;
        s_rsp_gnt  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                s_req_vld          = m_req_vld[owner_q];
                s_req_wr           = m_req_wr[owner_q];
                s_req_adr          = m_req_adr[int'(owner_q)*AW +: AW];
                s_req_strb         = m_req_strb[int'(owner_q)*SW +: SW];
                s_req_dat          = m_req_dat[int'(owner_q)*DW +: DW];
                m_req_gnt[owner_q] = s_req_gnt;
                // An owner withdrawing its request forfeits the slot without issuing anything.
                if (!m_req_vld[owner_q]) begin
                    state_d = ARB_IDLE;
                end else if (s_req_gnt) begin
                    state_d = ARB_RSP;
                end
            end
            ARB_RSP: begin
                m_rsp_vld[owner_q] = s_rsp_vld;
                s_rsp_gnt          = m_rsp_gnt[owner_q];
                if (s_rsp_vld && m_rsp_gnt[owner_q]) begin
                    state_d = ARB_IDLE;
`ifdef XFABRIC_ARB_LOCK_EN
                    if (m_req_lock[owner_q] && m_req_vld[owner_q]) begin
                        state_d = ARB_REQ;
                    end
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_xfabric_tgt_arbiter.sv
// Directed bench for xfabric_tgt_arbiter with three initiators and a 4-word dummy RAM target.
// Build with XFABRIC_ARB_LOCK_EN defined to exercise the ownership-lock ordering.
module tb_xfabric_tgt_arbiter;
    import xfabric_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req_vld, m_req_wr, m_req_gnt, m_rsp_vld, m_rsp_gnt;
    logic [N*AW-1:0] m_req_adr;
    logic [N*SW-1:0] m_req_strb;
    logic [N*DW-1:0] m_req_dat;
    logic [DW-1:0]   m_rsp_dat;
`ifdef XFABRIC_ARB_LOCK_EN
    logic [N-1:0]    m_req_lock;
`endif
    logic            s_req_vld, s_req_wr, s_req_gnt, s_rsp_vld, s_rsp_gnt;
    logic [AW-1:0]   s_req_adr;
    logic [SW-1:0]   s_req_strb;
    logic [DW-1:0]   s_req_dat, s_rsp_dat;
    arb_state_t      dbg_state;

    xfabric_tgt_arbiter #(.N_INIT(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .m_req_vld  (m_req_vld),
        .m_req_wr   (m_req_wr),
        .m_req_adr  (m_req_adr),
        .m_req_strb (m_req_strb),
        .m_req_dat  (m_req_dat),
        .m_req_gnt  (m_req_gnt),
        .m_rsp_vld  (m_rsp_vld),
        .m_rsp_dat  (m_rsp_dat),
        .m_rsp_gnt  (m_rsp_gnt),
`ifdef XFABRIC_ARB_LOCK_EN
        .m_req_lock (m_req_lock),
`endif
        .s_req_vld  (s_req_vld),
        .s_req_wr   (s_req_wr),
        .s_req_adr  (s_req_adr),
        .s_req_strb (s_req_strb),
        .s_req_dat  (s_req_dat),
        .s_req_gnt  (s_req_gnt),
        .s_rsp_vld  (s_rsp_vld),
        .s_rsp_dat  (s_rsp_dat),
        .s_rsp_gnt  (s_rsp_gnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- dummy RAM target: immediate grant, registered response ----------------
    logic [DW-1:0] ram [4];
    logic          rsp_pend;
    logic [DW-1:0] rsp_dat;

    assign s_req_gnt = s_req_vld & ~rsp_pend;
    assign s_rsp_vld = rsp_pend;
    assign s_rsp_dat = rsp_dat;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 4; b++) ram[b] <= '0;
            rsp_pend <= 1'b0;
            rsp_dat  <= '0;
        end else begin
            if (rsp_pend && s_rsp_gnt) rsp_pend <= 1'b0;
            if (s_req_vld && s_req_gnt) begin
                rsp_pend <= 1'b1;
                if (s_req_wr) begin
                    for (int b = 0; b < SW; b++)
                        if (s_req_strb[b]) ram[s_req_adr[3:2]][b*8 +: 8] <= s_req_dat[b*8 +: 8];
                    rsp_dat <= '0;
                end else begin
                    rsp_dat <= ram[s_req_adr[3:2]];
                end
            end
        end
    end

    // ---------------- initiator command queues and scoreboard ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] adr;
        logic [SW-1:0] strb;
        logic [DW-1:0] dat;
        logic          chk;
        logic [DW-1:0] exp;
        logic          lock;
    } cmd_t;

    cmd_t          cmd_q [N][$];
    logic [1:0]    exp_q[$];
    int            hold_left [N];
    bit            pend_vld;
    int            pend_init;
    logic          pend_chk;
    logic [DW-1:0] pend_exp;
    int            stray_rsp;
    bit            stall_chk;
    int            stall_cycles, stall_viol;
    int            n_checks, n_fail;

    task automatic push_cmd(input int i, input logic wr, input logic [AW-1:0] adr,
                            input logic [SW-1:0] strb, input logic [DW-1:0] dat,
                            input logic chk, input logic [DW-1:0] exp, input logic lock);
        cmd_t c;
        c.wr = wr; c.adr = adr; c.strb = strb; c.dat = dat;
        c.chk = chk; c.exp = exp; c.lock = lock;
        cmd_q[i].push_back(c);
    endtask

    task automatic drive_heads();
        cmd_t c;
        for (int i = 0; i < N; i++) begin
            if (cmd_q[i].size() > 0) begin
                c = cmd_q[i][0];
                m_req_vld[i]             = 1'b1;
                m_req_wr[i]              = c.wr;
                m_req_adr[i*AW +: AW]    = c.adr;
                m_req_strb[i*SW +: SW]   = c.strb;
                m_req_dat[i*DW +: DW]    = c.dat;
`ifdef XFABRIC_ARB_LOCK_EN
                m_req_lock[i]            = c.lock;
`endif
            end else begin
                m_req_vld[i]             = 1'b0;
                m_req_wr[i]              = 1'b0;
                m_req_adr[i*AW +: AW]    = '0;
                m_req_strb[i*SW +: SW]   = '0;
                m_req_dat[i*DW +: DW]    = '0;
`ifdef XFABRIC_ARB_LOCK_EN
                m_req_lock[i]            = 1'b0;
`endif
            end
            m_rsp_gnt[i] = (hold_left[i] == 0);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            cmd_q[i].delete();
            hold_left[i] = 0;
        end
        exp_q.delete();
        pend_vld  = 1'b0;
        stray_rsp = 0;
        drive_heads();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_bench();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Observe handshakes mid-cycle, then advance the initiators just after the edge.
    task automatic run(input string name, input int max_cycles);
        bit         done;
        logic [N-1:0] rf, sf, hv;
        logic [1:0] e;
        cmd_t       c;
        done = 1'b0;
        for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
            @(negedge clk);
            rf = m_req_vld & m_req_gnt;
            sf = m_rsp_vld & m_rsp_gnt;
            hv = m_rsp_vld;
            for (int i = 0; i < N; i++) begin
                if (m_rsp_vld[i] && !(pend_vld && pend_init == i)) stray_rsp++;
                if (rf[i]) begin
                    c = cmd_q[i][0];
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s req_order: m%0d issued, expected none", name, i);
                    end else begin
                        e = exp_q.pop_front();
                        if (e !== 2'(i)) begin
                            n_fail++;
                            $display("FAIL %s req_order: m%0d issued, expected m%0d", name, i, e);
                        end
                    end
                    n_checks++;
                    if ({s_req_wr, s_req_adr, s_req_strb, s_req_dat} !== {c.wr, c.adr, c.strb, c.dat}) begin
                        n_fail++;
                        $display("FAIL %s req_payload m%0d: got wr=%0b adr=%h strb=%h dat=%h expected wr=%0b adr=%h strb=%h dat=%h",
                                 name, i, s_req_wr, s_req_adr, s_req_strb, s_req_dat, c.wr, c.adr, c.strb, c.dat);
                    end
                    pend_vld  = 1'b1;
                    pend_init = i;
                    pend_chk  = c.chk;
                    pend_exp  = c.exp;
                end
                if (sf[i] && pend_vld && pend_init == i) begin
                    if (pend_chk) begin
                        n_checks++;
                        if (m_rsp_dat !== pend_exp) begin
                            n_fail++;
                            $display("FAIL %s rsp_dat m%0d: got %h expected %h", name, i, m_rsp_dat, pend_exp);
                        end
                    end
                    pend_vld = 1'b0;
                end
            end
            if (stall_chk && m_rsp_vld[2] && !m_rsp_gnt[2]) begin
                stall_cycles++;
                if (!s_rsp_vld || s_req_vld || m_req_gnt[0]) stall_viol++;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rf[i]) cmd_q[i].delete(0);
                if (hv[i] && hold_left[i] > 0) hold_left[i]--;
            end
            drive_heads();
            if (cmd_q[0].size() == 0 && cmd_q[1].size() == 0 && cmd_q[2].size() == 0 && !pend_vld)
                done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: not drained after %0d cycles", name, max_cycles);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s req_count: %0d expected requests never issued, expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({m_req_gnt, m_rsp_vld, s_req_vld, s_rsp_gnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b rsp_vld=%b s_req_vld=%b s_rsp_gnt=%b expected all 0",
                     m_req_gnt, m_rsp_vld, s_req_vld, s_rsp_gnt);
        end
        n_checks++;
        if (dbg_state !== ARB_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ARB_IDLE);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (dbg_state !== ARB_IDLE || s_req_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got state=%0d s_req_vld=%0b expected 0/0", dbg_state, s_req_vld);
        end
    endtask

    task automatic test_write_read();
        push_cmd(0, 1'b1, 21'h000004, 4'hF, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        push_cmd(0, 1'b0, 21'h000004, 4'h0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
        exp_q = '{2'd0, 2'd0};
        stray_rsp = 0;
        drive_heads();
        run("write_read", 40);
        n_checks++;
        if (stray_rsp !== 0) begin
            n_fail++;
            $display("FAIL write_read stray_rsp: got %0d expected 0", stray_rsp);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        push_cmd(0, 1'b1, 21'h000000, 4'hF, 32'hA0A0A0A0, 1'b0, '0, 1'b0);
        push_cmd(0, 1'b1, 21'h00000C, 4'hF, 32'hA3A3A3A3, 1'b0, '0, 1'b0);
        push_cmd(1, 1'b1, 21'h000004, 4'hF, 32'hB1B1B1B1, 1'b0, '0, 1'b0);
        push_cmd(2, 1'b1, 21'h000008, 4'hF, 32'hC2C2C2C2, 1'b0, '0, 1'b0);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
        drive_heads();
        @(negedge clk);
        n_checks++;
        if (s_req_vld !== 1'b0 || dbg_state !== ARB_IDLE) begin
            n_fail++;
            $display("FAIL rr_arb_cycle: got s_req_vld=%0b state=%0d expected 0/%0d", s_req_vld, dbg_state, ARB_IDLE);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (s_req_vld !== 1'b1 || m_req_gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL rr_latency: got s_req_vld=%0b gnt=%b expected 1/001", s_req_vld, m_req_gnt);
        end
        run("round_robin", 80);
    endtask

    task automatic test_rsp_stall();
        push_cmd(2, 1'b0, 21'h000008, 4'h0, '0, 1'b1, 32'hC2C2C2C2, 1'b0);
        push_cmd(0, 1'b0, 21'h00000C, 4'h0, '0, 1'b1, 32'hA3A3A3A3, 1'b0);
        exp_q = '{2'd2, 2'd0};
        hold_left[2] = 5;
        stall_cycles = 0;
        stall_viol   = 0;
        stall_chk    = 1'b1;
        drive_heads();
        run("rsp_stall", 80);
        stall_chk = 1'b0;
        n_checks++;
        if (stall_cycles !== 5) begin
            n_fail++;
            $display("FAIL rsp_stall cycles: got %0d expected 5", stall_cycles);
        end
        n_checks++;
        if (stall_viol !== 0) begin
            n_fail++;
            $display("FAIL rsp_stall isolation: got %0d bad cycles expected 0", stall_viol);
        end
    endtask

    task automatic test_strobe();
        push_cmd(1, 1'b1, 21'h000008, 4'hF, 32'h00000000, 1'b0, '0, 1'b0);
        push_cmd(1, 1'b1, 21'h000008, 4'b0010, 32'h11223344, 1'b0, '0, 1'b0);
        push_cmd(1, 1'b0, 21'h000008, 4'h0, '0, 1'b1, 32'h00003300, 1'b0);
        exp_q = '{2'd1, 2'd1, 2'd1};
        drive_heads();
        run("strobe", 60);
    endtask

    task automatic test_reset_mid();
        bit reached;
        reached = 1'b0;
        push_cmd(0, 1'b0, 21'h000004, 4'h0, '0, 1'b0, '0, 1'b0);
        hold_left[0] = 10;
        drive_heads();
        for (int k = 0; k < 10 && !reached; k++) begin
            @(posedge clk);
            #1;
            if (dbg_state == ARB_RSP) reached = 1'b1;
        end
        n_checks++;
        if (!reached || m_rsp_vld !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid setup: got reached=%0b rsp_vld=%b expected 1/001", reached, m_rsp_vld);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({m_req_gnt, m_rsp_vld, s_req_vld, s_rsp_gnt} !== '0 || dbg_state !== ARB_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got gnt=%b rsp_vld=%b s_req_vld=%b s_rsp_gnt=%b state=%0d expected all 0",
                     m_req_gnt, m_rsp_vld, s_req_vld, s_rsp_gnt, dbg_state);
        end
        clear_bench();
        @(posedge clk);
        #1 rstn = 1'b1;
        push_cmd(1, 1'b0, 21'h000000, 4'h0, '0, 1'b1, 32'h00000000, 1'b0);
        push_cmd(0, 1'b0, 21'h000000, 4'h0, '0, 1'b1, 32'h00000000, 1'b0);
        exp_q = '{2'd0, 2'd1};
        drive_heads();
        run("reset_mid", 60);
    endtask

    task automatic test_lock();
        do_reset();
        push_cmd(1, 1'b0, 21'h000000, 4'h0, '0, 1'b0, '0, 1'b1);
        push_cmd(1, 1'b0, 21'h000004, 4'h0, '0, 1'b0, '0, 1'b1);
        push_cmd(1, 1'b0, 21'h000008, 4'h0, '0, 1'b0, '0, 1'b1);
        drive_heads();
        @(posedge clk);
        #1;
        push_cmd(0, 1'b0, 21'h00000C, 4'h0, '0, 1'b0, '0, 1'b0);
`ifdef XFABRIC_ARB_LOCK_EN
        exp_q = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
        exp_q = '{2'd1, 2'd0, 2'd1, 2'd1};
`endif
        drive_heads();
        run("lock", 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        stall_chk = 1'b0;
        stall_cycles = 0;
        stall_viol   = 0;
        pend_init = 0;
        pend_chk  = 1'b0;
        pend_exp  = '0;
        clear_bench();
        test_reset();
        test_write_read();
        test_round_robin();
        test_rsp_stall();
        test_strobe();
        test_reset_mid();
        test_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
